// File: rtl/axis_rr_arbiter_if.sv
// axis_if: AXI-Stream bundle shared by the arbiter sources and the merged sink
interface axis_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEST_WIDTH = 2
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DEST_WIDTH-1:0] tdest;
   modport master (output tdata, tvalid, tlast, tdest, input tready);
   modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-locked round-robin merge of SLAVE_NUM streams into one registered stream
module axis_rr_arbiter #(
   parameter int SLAVE_NUM  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEST_WIDTH = $clog2(SLAVE_NUM)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   axis_if.slave                 s_axis [SLAVE_NUM-1:0],
   axis_if.master                m_axis,
   output logic [DEST_WIDTH-1:0] grant_o,
   output logic                  busy_o
);
   typedef enum logic {ARB, PKT} state_t;
   state_t                state, state_nxt;
   logic [DEST_WIDTH-1:0] last_grant, last_nxt, grant_nxt, pick, idx;
   logic                  found, load, accept;
   logic [DATA_WIDTH-1:0] s_tdata [SLAVE_NUM];
   logic                  s_tvalid [SLAVE_NUM];
   logic                  s_tlast [SLAVE_NUM];
   logic [DATA_WIDTH-1:0] q_data;
   logic                  q_valid, q_last;
   logic [DEST_WIDTH-1:0] q_dest;

   for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_src
      assign s_tdata[i]       = s_axis[i].tdata;
      assign s_tvalid[i]      = s_axis[i].tvalid;
      assign s_tlast[i]       = s_axis[i].tlast;
      assign s_axis[i].tready = (state == PKT) && (grant_o == DEST_WIDTH'(i)) && load;
   end

   assign load          = !q_valid || m_axis.tready;
   assign accept        = (state == PKT) && load && s_tvalid[grant_o];
   assign busy_o        = state == PKT;
   assign m_axis.tdata  = q_data;
   assign m_axis.tvalid = q_valid;
   assign m_axis.tlast  = q_last;
   assign m_axis.tdest  = q_dest;

   // first requester after last_grant; scanning farthest-first lets the nearest overwrite
   always_comb begin
      pick  = last_grant;
      found = 1'b0;
      idx   = '0;
      for (int k = SLAVE_NUM; k >= 1; k--) begin
         idx = DEST_WIDTH'((int'(last_grant) + k) % SLAVE_NUM);
         if (s_tvalid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // ARB picks a source for one cycle; PKT holds it until the tlast beat is taken
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_o;
      last_nxt  = last_grant;
      if (state == ARB) begin
         state_nxt = found ? PKT : ARB;
         grant_nxt = found ? pick : grant_o;
      end else if (accept && s_tlast[grant_o]) begin
         state_nxt = ARB;
         last_nxt  = grant_o;
      end
   end

   // arbitration state and priority pointer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ARB;
         grant_o    <= '0;
         last_grant <= DEST_WIDTH'(SLAVE_NUM - 1);
      end else begin
         state      <= state_nxt;
         grant_o    <= grant_nxt;
         last_grant <= last_nxt;
      end
   end

   // one-deep output stage: refill on accept, drain when downstream takes it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_valid <= 1'b0;
         q_data  <= '0;
         q_last  <= 1'b0;
         q_dest  <= '0;
      end else if (accept) begin
         q_valid <= 1'b1;
         q_data  <= s_tdata[grant_o];
         q_last  <= s_tlast[grant_o];
         q_dest  <= grant_o;
      end else if (m_axis.tready) begin
         q_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: scoreboard bench for the round-robin packet arbiter
module tb_axis_rr_arbiter;
   logic        clk = 1'b0, rst = 1'b1, m_ready = 1'b1;
   logic [31:0] sv_data [4];
   logic        sv_valid [4], sv_last [4], sv_ready [4];
   logic [1:0]  grant;
   logic        busy;
   logic [32:0] src_q [4][$];
   logic        src_hold [4] = '{default: 1'b0};
   logic        fire_s [4] = '{default: 1'b0};
   logic [34:0] exp_q [$];
   int          out_cyc [$];
   int          cyc = 0, n_chk = 0, n_pass = 0, ready_mode = 0, sc = 0;
   logic        prev_stall = 1'b0;
   logic [34:0] prev_beat, cur;

   axis_if #(.DATA_WIDTH(32), .DEST_WIDTH(2)) s_if [3:0] ();
   axis_if #(.DATA_WIDTH(32), .DEST_WIDTH(2)) m_if ();

   always #5 clk = ~clk;

   axis_rr_arbiter #(.SLAVE_NUM(4), .DATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .s_axis(s_if), .m_axis(m_if), .grant_o(grant), .busy_o(busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_src
      assign s_if[g].tdata  = sv_data[g];
      assign s_if[g].tvalid = sv_valid[g];
      assign s_if[g].tlast  = sv_last[g];
      assign s_if[g].tdest  = '0;
      assign sv_ready[g]    = s_if[g].tready;
   end
   assign m_if.tready = m_ready;
   assign cur = {m_if.tdest, m_if.tlast, m_if.tdata};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   function automatic logic [34:0] mk(input logic [1:0] d, input logic l, input logic [31:0] v);
      return {d, l, v};
   endfunction

   function automatic logic pending();
      logic p = exp_q.size() != 0 || busy;
      for (int i = 0; i < 4; i++) p |= src_q[i].size() != 0;
      return p;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic pkt(input int src, input logic [31:0] base, input int len, input logic ex);
      for (int k = 0; k < len; k++) begin
         src_q[src].push_back({k == len - 1, base + 32'(k)});
         if (ex) exp_q.push_back(mk(2'(src), k == len - 1, base + 32'(k)));
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (pending() && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("timeout", 64'(n), 0);
   endtask

   task automatic check_gaps(input string tag, input int len);
      for (int k = 1; k < out_cyc.size(); k++)
         check(tag, 64'(out_cyc[k] - out_cyc[k-1]), (k % len == 0) ? 64'd2 : 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         src_q[i].delete();
         src_hold[i] = 1'b0;
      end
      exp_q.delete();
      out_cyc.delete();
      rst = 1'b0;
      tick();
   endtask

   // source drivers and output monitor: drive on the falling edge, sample 1 ns later
   initial begin
      for (int i = 0; i < 4; i++) begin
         sv_data[i]  = '0;
         sv_valid[i] = 1'b0;
         sv_last[i]  = 1'b0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 4; i++) begin
            if (fire_s[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            sv_valid[i] = src_q[i].size() != 0 && !src_hold[i];
            sv_data[i]  = src_q[i].size() != 0 ? src_q[i][0][31:0] : 32'd0;
            sv_last[i]  = src_q[i].size() != 0 ? src_q[i][0][32] : 1'b0;
         end
         m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (sc % 4 == 0 || sc % 4 == 3) : 1'b0;
         if (ready_mode == 1) sc++;
         #1;
         for (int i = 0; i < 4; i++) fire_s[i] = sv_valid[i] && sv_ready[i] && !rst;
         check("onehot", 64'($countones({sv_ready[0], sv_ready[1], sv_ready[2], sv_ready[3]}) <= 1), 1);
         if (prev_stall && !rst) check("hold", 64'(cur), 64'(prev_beat));
         if (m_if.tvalid && !m_ready && !rst)
            check("stall_rdy", 64'({sv_ready[0], sv_ready[1], sv_ready[2], sv_ready[3]}), 0);
         if (m_if.tvalid && m_ready && !rst) begin
            if (exp_q.size() == 0) check("extra_beat", 64'(cur), 64'(exp_q.size()));
            else check("beat", 64'(cur), 64'(exp_q.pop_front()));
            out_cyc.push_back(cyc);
         end
         prev_stall = m_if.tvalid && !m_ready && !rst;
         prev_beat  = cur;
      end
   end

   initial begin
      tick(2);
      check("rst_tvalid", 64'(m_if.tvalid), 0);
      check("rst_tdata", 64'(m_if.tdata), 0);
      check("rst_tlast_dest", 64'({m_if.tlast, m_if.tdest}), 0);
      check("rst_grant_busy", 64'({grant, busy}), 0);
      check("rst_tready", 64'({sv_ready[0], sv_ready[1], sv_ready[2], sv_ready[3]}), 0);
      rst = 1'b0;
      tick();
      // single 3-beat packet from source 1
      pkt(1, 32'hA1, 3, 1'b1);
      tick();
      check("arb_grant", 64'(grant), 0);
      check("arb_busy", 64'(busy), 0);
      check("arb_rdy", 64'(sv_ready[1]), 0);
      tick();
      check("t1_grant", 64'(grant), 1);
      check("t1_busy", 64'(busy), 1);
      wait_done();
      check("t1_idle", 64'(busy), 0);
      check("t1_nbeats", 64'(out_cyc.size()), 3);
      check_gaps("t1_gap", 3);
      // alternating 2-beat packets from sources 0 and 2
      do_reset();
      pkt(0, 32'h10, 2, 1'b1);
      pkt(2, 32'h20, 2, 1'b1);
      pkt(0, 32'h12, 2, 1'b1);
      pkt(2, 32'h22, 2, 1'b1);
      wait_done();
      check("t2_nbeats", 64'(out_cyc.size()), 8);
      check_gaps("t2_gap", 2);
      // all four sources requesting single-beat packets
      do_reset();
      pkt(0, 32'h30, 1, 1'b1);
      pkt(1, 32'h31, 1, 1'b1);
      pkt(2, 32'h32, 1, 1'b1);
      pkt(3, 32'h33, 1, 1'b1);
      pkt(0, 32'h34, 1, 1'b1);
      wait_done();
      check("t3_nbeats", 64'(out_cyc.size()), 5);
      check_gaps("t3_gap", 1);
      // 4-beat packet from source 3 under downstream backpressure
      tick(2);
      sc = 0;
      ready_mode = 1;
      pkt(3, 32'h40, 4, 1'b1);
      wait_done();
      ready_mode = 0;
      check("t4_grant", 64'(grant), 3);
      // source 0 stalls mid-packet while source 1 waits
      tick(2);
      pkt(0, 32'h50, 3, 1'b1);
      pkt(1, 32'h60, 1, 1'b1);
      for (int n = 0; n < 100 && src_q[0].size() != 2; n++) tick();
      check("t5_reach", 64'(src_q[0].size()), 2);
      src_hold[0] = 1'b1;
      repeat (5) begin
         tick();
         check("t5_grant", 64'(grant), 0);
         check("t5_busy", 64'(busy), 1);
         check("t5_rdy1", 64'(sv_ready[1]), 0);
      end
      src_hold[0] = 1'b0;
      wait_done();
      check("t5_regrant", 64'(grant), 1);
      // asynchronous reset while a mid-packet beat sits in the output stage
      tick(2);
      pkt(0, 32'h70, 4, 1'b0);
      exp_q.push_back(mk(2'd0, 1'b0, 32'h70));
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
      check("t6_first", 64'(exp_q.size()), 0);
      ready_mode = 2;
      tick();
      check("t6_buffered", 64'({m_if.tvalid, m_if.tdata}), 64'({1'b1, 32'h71}));
      #1 rst = 1'b1;
      #1;
      check("t6_async_tvalid", 64'(m_if.tvalid), 0);
      check("t6_async_busy", 64'(busy), 0);
      for (int i = 0; i < 4; i++) src_q[i].delete();
      ready_mode = 0;
      tick(2);
      rst = 1'b0;
      tick();
      pkt(0, 32'h80, 1, 1'b1);
      pkt(3, 32'h83, 1, 1'b1);
      tick(2);
      check("t6_grant", 64'(grant), 0);
      wait_done();
      tick(2);
      check("drain", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
